// File: rtl/warp_ibuffer_pkg.sv
// Shared warp-count constants, the instruction-buffer entry type and a one-hot helper.
// Used by warp_ibuffer (optional IBUF_STATS_EN build), its per-warp FIFO and the handshake interface.
package defines;

  localparam int NUM_WARPS_PER_SM = 4;
  localparam int WARP_ID_W        = $clog2(NUM_WARPS_PER_SM);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

  // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
  function automatic logic is_onehot32(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/warp_ibuffer_if.sv
// Fetch / arbiter / issue handshake bundle around warp_ibuffer.
// master = fetch, arbiter and issue-stage side; slave = the instruction buffer side.
interface warp_ibuffer_if
  import defines::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_PER_SM
);
  logic                 fetch_valid;
  logic [WARP_ID_W-1:0] fetch_warp_id;
  logic [31:0]          fetch_pc;
  logic [31:0]          fetch_instr;
  logic [NUM_WARPS-1:0] ibuf_full;
  logic [NUM_WARPS-1:0] request;
  logic [NUM_WARPS-1:0] grantOH;
  logic                 issue_ready;
  logic                 issue_valid;
  logic [WARP_ID_W-1:0] issue_warp_id;
  logic [31:0]          issue_pc;
  logic [31:0]          issue_instr;
  logic                 flush;
  logic [WARP_ID_W-1:0] flush_warp_id;

  modport master (
    output fetch_valid, fetch_warp_id, fetch_pc, fetch_instr, grantOH, issue_ready,
           flush, flush_warp_id,
    input  ibuf_full, request, issue_valid, issue_warp_id, issue_pc, issue_instr
  );

  modport slave (
    input  fetch_valid, fetch_warp_id, fetch_pc, fetch_instr, grantOH, issue_ready,
           flush, flush_warp_id,
    output ibuf_full, request, issue_valid, issue_warp_id, issue_pc, issue_instr
  );
endinterface

// File: rtl/warp_ibuf_fifo.sv
// Single-warp circular instruction FIFO with wrap-around head/tail pointers.
// Flush empties the FIFO and wins over a same-cycle push or pop.
module warp_ibuf_fifo
  import defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  ibuf_entry_t push_entry,
  input  logic        pop,
  input  logic        flush,
  output ibuf_entry_t head_entry,
  output logic        empty,
  output logic        full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ibuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_push    = push && !full && !flush;
  assign do_pop     = pop && !empty && !flush;
  assign head_entry = mem[head_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_reg] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffers feeding one issue register through a one-hot arbiter grant.
// Define IBUF_STATS_EN to add the per-warp saturating pop counters on issue_count.
module warp_ibuffer
  import defines::*;
#(
  parameter int NUM_WARPS  = NUM_WARPS_PER_SM,
  parameter int IBUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [WARP_ID_W-1:0] fetch_warp_id,
  input  logic [31:0]          fetch_pc,
  input  logic [31:0]          fetch_instr,
  output logic [NUM_WARPS-1:0] ibuf_full,
  output logic [NUM_WARPS-1:0] request,
  input  logic [NUM_WARPS-1:0] grantOH,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [WARP_ID_W-1:0] issue_warp_id,
  output logic [31:0]          issue_pc,
  output logic [31:0]          issue_instr,
  input  logic                 flush,
  input  logic [WARP_ID_W-1:0] flush_warp_id
`ifdef IBUF_STATS_EN
  ,
  output logic [NUM_WARPS-1:0][15:0] issue_count
`endif
);

  ibuf_entry_t          head_w [NUM_WARPS];
  ibuf_entry_t          fetch_entry;
  ibuf_entry_t          sel_entry;
  logic [WARP_ID_W-1:0] sel_warp;
  logic [NUM_WARPS-1:0] empty_w;
  logic [NUM_WARPS-1:0] full_w;
  logic [NUM_WARPS-1:0] push_w;
  logic [NUM_WARPS-1:0] pop_w;
  logic [NUM_WARPS-1:0] flush_w;
  logic                 slot_free;
  logic                 grant_ok;
  logic                 any_pop;

  logic                 issue_valid_reg;
  logic [WARP_ID_W-1:0] issue_warp_reg;
  ibuf_entry_t          issue_entry_reg;

  assign fetch_entry = '{pc: fetch_pc, instr: fetch_instr};
  assign slot_free   = !issue_valid_reg || issue_ready;
  assign grant_ok    = is_onehot32(32'(grantOH));
  assign any_pop     = |pop_w;
  assign ibuf_full   = full_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign flush_w[gi] = flush && (flush_warp_id == WARP_ID_W'(gi));
      assign push_w[gi]  = fetch_valid && (fetch_warp_id == WARP_ID_W'(gi)) && !full_w[gi];
      assign request[gi] = !empty_w[gi] && slot_free;
      // A flushed warp never pops, so its head cannot slip into the issue register.
      assign pop_w[gi]   = grant_ok && grantOH[gi] && !empty_w[gi] && slot_free && !flush_w[gi];

      warp_ibuf_fifo #(
        .DEPTH(IBUF_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_w[gi]),
        .push_entry(fetch_entry),
        .pop       (pop_w[gi]),
        .flush     (flush_w[gi]),
        .head_entry(head_w[gi]),
        .empty     (empty_w[gi]),
        .full      (full_w[gi])
      );

`ifdef IBUF_STATS_EN
      logic [15:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (pop_w[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign issue_count[gi] = cnt_reg;
`endif
    end
  endgenerate

  always_comb begin
    sel_entry = '0;
    sel_warp  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (pop_w[i]) begin
        sel_entry = head_w[i];
        sel_warp  = WARP_ID_W'(i);
      end
    end
  end

  // A pop reloads back-to-back; otherwise consumption or a flush of the stalled warp empties the slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid_reg <= 1'b0;
      issue_warp_reg  <= '0;
      issue_entry_reg <= '0;
    end else if (any_pop) begin
      issue_valid_reg <= 1'b1;
      issue_warp_reg  <= sel_warp;
      issue_entry_reg <= sel_entry;
    end else if (issue_valid_reg && issue_ready) begin
      issue_valid_reg <= 1'b0;
    end else if (flush && issue_valid_reg && (issue_warp_reg == flush_warp_id)) begin
      issue_valid_reg <= 1'b0;
    end
  end

  assign issue_valid   = issue_valid_reg;
  assign issue_warp_id = issue_warp_reg;
  assign issue_pc      = issue_entry_reg.pc;
  assign issue_instr   = issue_entry_reg.instr;

endmodule

// File: tb/tb_warp_ibuffer.sv
// Self-checking bench for warp_ibuffer: directed vector table, hand sequences and a queue model.
// Build with IBUF_STATS_EN to also check the saturating issue_count outputs.
module tb_warp_ibuffer;
  import defines::*;

  localparam int NW    = 4;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  warp_ibuffer_if #(.NUM_WARPS(NW)) bus ();
`ifdef IBUF_STATS_EN
  logic [NW-1:0][15:0] issue_count;
`endif

  warp_ibuffer #(.NUM_WARPS(NW), .IBUF_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (bus.fetch_valid),
    .fetch_warp_id(bus.fetch_warp_id),
    .fetch_pc     (bus.fetch_pc),
    .fetch_instr  (bus.fetch_instr),
    .ibuf_full    (bus.ibuf_full),
    .request      (bus.request),
    .grantOH      (bus.grantOH),
    .issue_ready  (bus.issue_ready),
    .issue_valid  (bus.issue_valid),
    .issue_warp_id(bus.issue_warp_id),
    .issue_pc     (bus.issue_pc),
    .issue_instr  (bus.issue_instr),
    .flush        (bus.flush),
    .flush_warp_id(bus.flush_warp_id)
`ifdef IBUF_STATS_EN
    ,
    .issue_count  (issue_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain per-warp queues plus the issue slot.
  logic [63:0]          mq [NW][DEPTH];
  int                   msz [NW];
  logic                 mv;
  logic [WARP_ID_W-1:0] mw;
  logic [31:0]          mpc, minstr;
  int                   mstat [NW];

  function automatic logic [NW-1:0] exp_full();
    logic [NW-1:0] f;
    for (int w = 0; w < NW; w++) f[w] = (msz[w] == DEPTH);
    return f;
  endfunction

  function automatic logic [NW-1:0] exp_req();
    logic [NW-1:0] r;
    for (int w = 0; w < NW; w++) r[w] = (msz[w] != 0) && (!mv || bus.issue_ready);
    return r;
  endfunction

  task automatic model_edge();
    logic        slot_free, do_pop, do_push;
    int          gw, pw, fw;
    logic [63:0] ent;
    if (!reset) begin
      for (int w = 0; w < NW; w++) begin msz[w] = 0; mstat[w] = 0; end
      mv = 1'b0; mw = '0; mpc = '0; minstr = '0;
      return;
    end
    slot_free = !mv || bus.issue_ready;
    gw = 0;
    for (int w = 0; w < NW; w++) if (bus.grantOH[w]) gw = w;
    fw = int'(bus.flush_warp_id);
    pw = int'(bus.fetch_warp_id);
    do_pop  = ($countones(bus.grantOH) == 1) && (msz[gw] > 0) && slot_free && !(bus.flush && fw == gw);
    do_push = bus.fetch_valid && (msz[pw] < DEPTH) && !(bus.flush && fw == pw);
    if (do_pop) begin
      ent = mq[gw][0];
      mv = 1'b1; mw = WARP_ID_W'(gw); mpc = ent[63:32]; minstr = ent[31:0];
      if (mstat[gw] < 65535) mstat[gw]++;
      for (int i = 0; i < DEPTH - 1; i++) mq[gw][i] = mq[gw][i+1];
      msz[gw]--;
    end else if (mv && bus.issue_ready) begin
      mv = 1'b0;
    end else if (bus.flush && mv && int'(mw) == fw) begin
      mv = 1'b0;
    end
    if (do_push) begin
      mq[pw][msz[pw]] = {bus.fetch_pc, bus.fetch_instr};
      msz[pw]++;
    end
    if (bus.flush) msz[fw] = 0;
  endtask

  task automatic settle();
    #1;
    chk("ibuf_full", 64'(bus.ibuf_full), 64'(exp_full()));
    chk("request", 64'(bus.request), 64'(exp_req()));
    chk("issue_valid", 64'(bus.issue_valid), 64'(mv));
    chk("issue_warp_id", 64'(bus.issue_warp_id), 64'(mw));
    chk("issue_pc", 64'(bus.issue_pc), 64'(mpc));
    chk("issue_instr", 64'(bus.issue_instr), 64'(minstr));
`ifdef IBUF_STATS_EN
    for (int w = 0; w < NW; w++) chk($sformatf("issue_count[%0d]", w), 64'(issue_count[w]), 64'(mstat[w]));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'hBEEF};
  endfunction

  task automatic drive(input bit fv, input int fw, input logic [31:0] fpc, input logic [3:0] gnt,
                       input bit rdy, input bit fl, input int flw);
    bus.fetch_valid   = fv;
    bus.fetch_warp_id = WARP_ID_W'(fw);
    bus.fetch_pc      = fpc;
    bus.fetch_instr   = instr_of(fpc);
    bus.grantOH       = gnt;
    bus.issue_ready   = rdy;
    bus.flush         = fl;
    bus.flush_warp_id = WARP_ID_W'(flw);
  endtask

  typedef struct {
    bit fv; int fw; logic [31:0] fpc; logic [3:0] gnt; bit rdy; bit fl; int flw;
    logic [3:0] e_full; logic [3:0] e_req; bit e_v; int e_w; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit fv, int fw, logic [31:0] fpc, logic [3:0] gnt, bit rdy, bit fl,
                              int flw, logic [3:0] ef, logic [3:0] er, bit ev, int ew, logic [31:0] ep);
    vec_t v;
    v.fv = fv; v.fw = fw; v.fpc = fpc; v.gnt = gnt; v.rdy = rdy; v.fl = fl; v.flw = flw;
    v.e_full = ef; v.e_req = er; v.e_v = ev; v.e_w = ew; v.e_pc = ep;
    tbl.push_back(v);
  endfunction

  initial begin
    for (int w = 0; w < NW; w++) begin msz[w] = 0; mstat[w] = 0; end
    mv = 1'b0; mw = '0; mpc = '0; minstr = '0;

    // Expectations describe the outputs seen in the cycle the inputs are applied.
    add(1,2,32'h100,4'h0,1,0,0, 4'h0,4'h0,0,0,32'h0);
    add(0,0,32'h0,  4'h4,1,0,0, 4'h0,4'h4,0,0,32'h0);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,1,2,32'h100);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,0,2,32'h100);
    add(1,0,32'h200,4'h0,1,0,0, 4'h0,4'h0,0,2,32'h100);
    add(1,0,32'h204,4'h0,1,0,0, 4'h0,4'h1,0,2,32'h100);
    add(1,0,32'h208,4'h0,1,0,0, 4'h1,4'h1,0,2,32'h100);
    add(0,0,32'h0,  4'h1,1,0,0, 4'h1,4'h1,0,2,32'h100);
    add(0,0,32'h0,  4'h1,1,0,0, 4'h0,4'h1,1,0,32'h200);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,1,0,32'h204);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,0,0,32'h204);
    add(1,1,32'h300,4'h0,1,0,0, 4'h0,4'h0,0,0,32'h204);
    add(1,1,32'h304,4'h0,1,0,0, 4'h0,4'h2,0,0,32'h204);
    add(0,0,32'h0,  4'h2,1,0,0, 4'h2,4'h2,0,0,32'h204);
    add(0,0,32'h0,  4'h0,0,0,0, 4'h0,4'h0,1,1,32'h300);
    add(0,0,32'h0,  4'h2,0,0,0, 4'h0,4'h0,1,1,32'h300);
    add(0,0,32'h0,  4'h2,1,0,0, 4'h0,4'h2,1,1,32'h300);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,1,1,32'h304);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,0,1,32'h304);
    add(1,1,32'h400,4'h0,1,0,0, 4'h0,4'h0,0,1,32'h304);
    add(1,1,32'h404,4'h0,1,0,0, 4'h0,4'h2,0,1,32'h304);
    add(1,1,32'h408,4'h2,1,1,1, 4'h2,4'h2,0,1,32'h304);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,0,1,32'h304);
    add(1,0,32'h500,4'h0,1,0,0, 4'h0,4'h0,0,1,32'h304);
    add(1,1,32'h600,4'h0,1,0,0, 4'h0,4'h1,0,1,32'h304);
    add(0,0,32'h0,  4'h3,1,0,0, 4'h0,4'h3,0,1,32'h304);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h3,0,1,32'h304);
    add(0,0,32'h0,  4'h1,1,0,0, 4'h0,4'h3,0,1,32'h304);
    add(0,0,32'h0,  4'h2,1,0,0, 4'h0,4'h2,1,0,32'h500);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,1,1,32'h600);
    add(0,0,32'h0,  4'h0,1,0,0, 4'h0,4'h0,0,1,32'h600);

    drive(0,0,32'h0,4'h0,1,0,0);
    reset = 1'b0;
    advance();
    advance();
    reset = 1'b1;
    #1;
    chk("reset ibuf_full", 64'(bus.ibuf_full), 64'h0);
    chk("reset request", 64'(bus.request), 64'h0);
    chk("reset issue_valid", 64'(bus.issue_valid), 64'h0);
    chk("reset issue_warp_id", 64'(bus.issue_warp_id), 64'h0);
    chk("reset issue_pc", 64'(bus.issue_pc), 64'h0);
    chk("reset issue_instr", 64'(bus.issue_instr), 64'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].fv, tbl[i].fw, tbl[i].fpc, tbl[i].gnt, tbl[i].rdy, tbl[i].fl, tbl[i].flw);
      settle();
      chk($sformatf("v%0d full", i), 64'(bus.ibuf_full), 64'(tbl[i].e_full));
      chk($sformatf("v%0d request", i), 64'(bus.request), 64'(tbl[i].e_req));
      chk($sformatf("v%0d valid", i), 64'(bus.issue_valid), 64'(tbl[i].e_v));
      chk($sformatf("v%0d warp", i), 64'(bus.issue_warp_id), 64'(tbl[i].e_w));
      chk($sformatf("v%0d pc", i), 64'(bus.issue_pc), 64'(tbl[i].e_pc));
      advance();
    end

    // Five push/pop pairs on warp 3 walk the pointers around the ring.
    for (int k = 0; k < 5; k++) begin
      drive(1,3,32'h700 + 32'(4*k),4'h0,1,0,0); settle(); advance();
      drive(0,0,32'h0,4'h8,1,0,0);              settle(); advance();
      drive(0,0,32'h0,4'h0,1,0,0);              settle();
      chk($sformatf("wrap%0d valid", k), 64'(bus.issue_valid), 64'h1);
      chk($sformatf("wrap%0d pc", k), 64'(bus.issue_pc), 64'(32'h700 + 32'(4*k)));
      advance();
    end

    // Reset in the middle of a grant discards everything.
    drive(1,0,32'h800,4'h0,1,0,0); settle(); advance();
    drive(1,2,32'h900,4'h0,1,0,0); settle(); advance();
    drive(1,1,32'hA00,4'h1,1,0,0); settle();
    reset = 1'b0;
    advance();
    reset = 1'b1;
    drive(0,0,32'h0,4'h0,1,0,0);
    #1;
    chk("midreset valid", 64'(bus.issue_valid), 64'h0);
    chk("midreset full", 64'(bus.ibuf_full), 64'h0);
    chk("midreset request", 64'(bus.request), 64'h0);
    chk("midreset pc", 64'(bus.issue_pc), 64'h0);
    advance();

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] g;
      if ($urandom_range(0, 7) < 5) g = 4'(1 << $urandom_range(0, 3));
      else                          g = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)), $urandom, g,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
      bus.fetch_instr = $urandom;
      settle();
      advance();
    end
    reset = 1'b1;

`ifdef IBUF_STATS_EN
    drive(0,0,32'h0,4'h0,1,0,0); settle(); advance();
    force dut.g_warp[0].cnt_reg = 16'hFFFE;
    #1;
    release dut.g_warp[0].cnt_reg;
    mstat[0] = 65534;
    for (int k = 0; k < 3; k++) begin
      drive(1,0,32'hC00 + 32'(4*k),4'h0,1,0,0); settle(); advance();
      drive(0,0,32'h0,4'h1,1,0,0);              settle(); advance();
      chk($sformatf("stat sat%0d", k), 64'(issue_count[0]), 64'hFFFF);
    end
`endif

    drive(0,0,32'h0,4'h0,1,0,0);
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/warp_ibuffer.md
WARP_IBUFFER -- requirements
Module: warp_ibuffer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default NUM_WARPS_PER_SM (4): number of warps served.
REQ-002 SHALL have parameter IBUF_DEPTH, default 2: entries per warp FIFO, power of two, at least 2.
REQ-003 SHALL have ports, in this order:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- fetch_valid  input  1  instruction presented by fetch.
- fetch_warp_id  input  WARP_ID_W  owning warp of the fetched instruction.
- fetch_pc  input  32  PC of the fetched instruction.
- fetch_instr  input  32  instruction word.
- ibuf_full  output  NUM_WARPS  per-warp FIFO full, back-pressure to fetch.
- request  output  NUM_WARPS  per-warp issue request to the round-robin arbiter.
- grantOH  input  NUM_WARPS  one-hot grant from the arbiter.
- issue_ready  input  1  issue/operand stage accepts the issue register.
- issue_valid  output  1  issue register holds an instruction.
- issue_warp_id  output  WARP_ID_W  warp of the issued instruction.
- issue_pc  output  32  PC of the issued instruction.
- issue_instr  output  32  issued instruction word.
- flush  input  1  discard the buffered instructions of one warp (branch redirect).
- flush_warp_id  input  WARP_ID_W  warp to flush.

Function
REQ-004 SHALL keep one circular FIFO per warp of IBUF_DEPTH entries {pc, instr}, with head and tail pointers that wrap modulo IBUF_DEPTH and a count ranging 0..IBUF_DEPTH.
REQ-005 SHALL drive ibuf_full[w] = (count[w] == IBUF_DEPTH), taken from registers only.
REQ-006 SHALL push on fetch_valid && !ibuf_full[fetch_warp_id]; a push into a full warp is dropped and leaves all state unchanged.
REQ-007 SHALL define slot_free = !issue_valid || issue_ready.
REQ-008 SHALL drive request[w] = (count[w] != 0) && slot_free, combinationally from registers and issue_ready.
REQ-009 SHALL pop when grantOH is non-zero and one-hot, the granted warp has count != 0, and slot_free; the head entry loads into the issue register at the next edge and issue_valid goes to 1.
REQ-010 SHALL ignore a zero or non-one-hot grantOH: no pop occurs.
REQ-011 SHALL clear issue_valid at the edge after issue_valid && issue_ready when no pop occurs in that cycle; a pop in the same cycle replaces the register contents back-to-back.
REQ-012 SHALL hold all issue_* outputs stable while issue_valid && !issue_ready.
REQ-013 SHALL leave count unchanged on a simultaneous push and pop to the same warp; a push into an empty FIFO becomes requestable no earlier than the next cycle.
REQ-014 SHALL, on flush, set count, head and tail of flush_warp_id to 0; flush takes priority over a same-cycle push or pop to that warp.
REQ-015 SHALL, on flush, clear issue_valid if the issue register holds flush_warp_id and issue_ready is 0.
REQ-016 SHALL keep the operations of different warps in the same cycle independent.

Reset
REQ-017 SHALL, while reset == 0 at a clock edge, clear every count, head and tail to 0 and issue_valid to 0.
REQ-018 SHALL, after reset, present ibuf_full = 0, request = 0, issue_warp_id = 0, issue_pc = 0 and issue_instr = 0.
REQ-019 SHALL let reset asserted mid-operation discard all buffered and in-flight instructions with no pop or issue.

Configuration
REQ-020 SHALL, with IBUF_STATS_EN defined, provide output issue_count (NUM_WARPS x 16): a per-warp saturating count of pops that holds at 16'hFFFF, is cleared by reset and is not cleared by flush.
REQ-021 SHALL, without IBUF_STATS_EN, omit the issue_count port and its logic.

Structure
REQ-022 SHALL take NUM_WARPS_PER_SM, WARP_ID_W = $clog2(NUM_WARPS_PER_SM) and the ibuf_entry_t typedef {pc[31:0], instr[31:0]} from package defines.
REQ-023 SHALL implement the per-warp FIFO as sub-module warp_ibuf_fifo, instantiated NUM_WARPS times, with the issue register and grant decode kept in warp_ibuffer.

Verification
REQ-024 SHALL cover: reset, then push warp 2 (pc 0x100) at cycle 0 -> request = 4'b0100 at cycle 1; grantOH = 4'b0100 at cycle 1 -> issue_valid = 1, issue_pc = 0x100, issue_warp_id = 2 at cycle 2.
REQ-025 SHALL cover: push 3 entries to warp 0 with no grant -> ibuf_full[0] = 1 after 2 pushes; 3rd push dropped; two pops return the first two pcs in order.
REQ-026 SHALL cover: issue_ready = 0 with issue_valid = 1 -> request = 0 and outputs held; issue_ready = 1 -> next granted entry issued back-to-back with no bubble.
REQ-027 SHALL cover: warp 1 full, flush warp 1 concurrent with push and grant to warp 1 -> count[1] = 0, no issue, ibuf_full[1] = 0.
REQ-028 SHALL cover: grantOH = 4'b0011 -> no pop; and head/tail wrap after 5 push/pop pairs on warp 3 -> pcs issued in push order.
REQ-029 SHALL cover: with IBUF_STATS_EN, pops to warp 0 with issue_count[0] preloaded by force to 16'hFFFE -> reaches 16'hFFFF and holds.
